// File: rtl/la_pkg.sv
// Shared definitions for the la_capture logic-analyser front end:
// record field offsets (all derived from the channel count N) and the
// legal debounce length range.
package la_pkg;

    localparam int DB_MIN = 1;
    localparam int DB_MAX = 4;

    // Channel levels sit at the bottom of the record.
    function automatic int rec_pin_lsb(input int n);
        return n * 0;
    endfunction

    // Overflow flag sits directly above the channel levels.
    function automatic int rec_oflow(input int n);
        return n;
    endfunction

    // Timestamp occupies the top of the record.
    function automatic int rec_ts_lsb(input int n);
        return n + 1;
    endfunction

endpackage

// File: rtl/la_edge_detect.sv
// One capture channel: 2-flop synchroniser, 2*DB sample history and
// registered debounced rise/fall strobes.
//
// A rise needs DB consecutive ones directly preceded by DB consecutive
// zeros. A fall is the mirror pattern. The registered strobes put the
// event DB+1 cycles after the synchronised input first changes.
module la_edge_detect #(
    parameter int DB = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic smp,
    output logic rise,
    output logic fall
);

    logic [1:0]      sync;
    logic [2*DB-1:0] h;

    // Synchronise, shift the history (h[0] newest) and detect debounced edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            h    <= '0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            sync <= {sync[0], pin};
            h    <= {h[2*DB-2:0], sync[1]};
            rise <= (&h[DB-1:0]) & ~(|h[2*DB-1:DB]);
            fall <= ~(|h[DB-1:0]) & (&h[2*DB-1:DB]);
        end
    end

    // Level reported in records is the newest history sample.
    assign smp = h[0];

endmodule

// File: rtl/la_capture.sv
// Logic-analyser capture front end. Debounces N channels, timestamps
// qualified edges and timebase rollovers, buffers records in a
// 2**AW-deep first-word-fall-through FIFO and streams them out on a
// valid/ready interface. A full FIFO drops events and raises oflow_pend;
// the next stored record carries oflow=1 and clears it.
//
// Optional build macro LA_DROPCNT_EN adds a 16-bit saturating drop_cnt
// output counting events lost since the last oflow record was stored.
module la_capture
    import la_pkg::*;
#(
    parameter int N    = 7,
    parameter int TS_W = 24,
    parameter int AW   = 11,
    parameter int DB   = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N-1:0]        pin,
    input  logic [N-1:0]        rise_en,
    input  logic [N-1:0]        fall_en,
    input  logic                enable,
    output logic [TS_W+N:0]     rec_data,
    output logic                rec_valid,
    input  logic                rec_ready,
    output logic [AW:0]         level,
    output logic                oflow_pend
`ifdef LA_DROPCNT_EN
    ,
    output logic [15:0]         drop_cnt
`endif
);

    localparam int REC_W = TS_W + 1 + N;
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] FULL_LVL = {1'b1, {AW{1'b0}}};

    if (DB < DB_MIN || DB > DB_MAX) begin : g_db_range
        $error("la_capture: DB out of range");
    end

    logic [N-1:0]      smp, rise, fall;
    logic [TS_W-1:0]   ts_q;
    logic              roll_q;
    logic              ev, trig, full, wr, drop, pop, rd;
    logic [AW-1:0]     wptr, rptr;
    logic [AW:0]       ram_cnt;
    logic [REC_W-1:0]  rec_in;
    logic [REC_W-1:0]  mem [DEPTH];

    for (genvar i = 0; i < N; i++) begin : g_ch
        la_edge_detect #(.DB(DB)) u_ed (
            .clk   (clk),
            .rst_n (rst_n),
            .pin   (pin[i]),
            .smp   (smp[i]),
            .rise  (rise[i]),
            .fall  (fall[i])
        );
    end

    // Free-running timebase; roll_q marks the ts==0 cycle following a wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q   <= '0;
            roll_q <= 1'b0;
        end else begin
            ts_q   <= ts_q + TS_W'(1);
            roll_q <= (ts_q == '1);
        end
    end

    // Coincident edges and rollover collapse into a single trigger.
    assign ev   = |((rise & rise_en) | (fall & fall_en));
    assign trig = enable & (ev | roll_q);
    assign full = (level == FULL_LVL);
    assign wr   = trig & ~full;
    assign drop = trig & full;
    assign pop  = rec_valid & rec_ready;
    // Refill the output register whenever it is empty or being consumed.
    assign rd   = (ram_cnt != '0) & (~rec_valid | rec_ready);

    // Assemble the record from the trigger-cycle state.
    always_comb begin
        rec_in = '0;
        rec_in[rec_pin_lsb(N) +: N]   = smp;
        rec_in[rec_oflow(N)]          = oflow_pend;
        rec_in[rec_ts_lsb(N) +: TS_W] = ts_q;
    end

    // Record storage; no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr)
            mem[wptr] <= rec_in;
    end

    // Write pointer and count of records still held in RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr    <= '0;
            ram_cnt <= '0;
        end else begin
            if (wr)
                wptr <= wptr + AW'(1);
            if (wr && !rd)
                ram_cnt <= ram_cnt + (AW+1)'(1);
            else if (!wr && rd)
                ram_cnt <= ram_cnt - (AW+1)'(1);
        end
    end

    // Registered RAM read doubles as the output stage (first-word-fall-through).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr      <= '0;
            rec_valid <= 1'b0;
            rec_data  <= '0;
        end else if (rd) begin
            rec_data  <= mem[rptr];
            rptr      <= rptr + AW'(1);
            rec_valid <= 1'b1;
        end else if (pop) begin
            rec_valid <= 1'b0;
        end
    end

    // Total occupancy (RAM plus output stage); full/empty decisions use this.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            level <= '0;
        else if (wr && !pop)
            level <= level + (AW+1)'(1);
        else if (!wr && pop)
            level <= level - (AW+1)'(1);
    end

    // Loss flag: set on a drop, cleared once a record reports it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            oflow_pend <= 1'b0;
        else if (drop)
            oflow_pend <= 1'b1;
        else if (wr && oflow_pend)
            oflow_pend <= 1'b0;
    end

`ifdef LA_DROPCNT_EN
    // Saturating count of drops since the last oflow record was stored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            drop_cnt <= '0;
        else if (wr && oflow_pend)
            drop_cnt <= drop ? 16'd1 : 16'd0;
        else if (drop && drop_cnt != 16'hFFFF)
            drop_cnt <= drop_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_la_capture.sv
// Bench for la_capture: N=7, TS_W=6, AW=2, DB=2. Expected records are
// queued when stimulus is driven and compared as the DUT hands them out.
module tb_la_capture;

    localparam int N     = 7;
    localparam int TS_W  = 6;
    localparam int AW    = 2;
    localparam int DB    = 2;
    localparam int REC_W = TS_W + 1 + N;
    localparam int LAT   = 2 + DB + 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      pin, rise_en, fall_en;
    logic              enable, rec_ready;
    logic [REC_W-1:0]  rec_data;
    logic              rec_valid;
    logic [AW:0]       level;
    logic              oflow_pend;
`ifdef LA_DROPCNT_EN
    logic [15:0]       drop_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [REC_W-1:0] exp_q [$];
    logic [TS_W-1:0]  tb_ts;
    logic [TS_W-1:0]  te;

    la_capture #(.N(N), .TS_W(TS_W), .AW(AW), .DB(DB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pin        (pin),
        .rise_en    (rise_en),
        .fall_en    (fall_en),
        .enable     (enable),
        .rec_data   (rec_data),
        .rec_valid  (rec_valid),
        .rec_ready  (rec_ready),
        .level      (level),
        .oflow_pend (oflow_pend)
`ifdef LA_DROPCNT_EN
        ,
        .drop_cnt   (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Independent timebase reference: cycles since reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_ts <= '0;
        else        tb_ts <= tb_ts + 1'b1;
    end

    // Scoreboard: every handshake must match the oldest expected record.
    always @(negedge clk) begin
        if (rst_n && rec_valid && rec_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_record got %h", rec_data);
            end else begin
                logic [REC_W-1:0] e;
                e = exp_q.pop_front();
                if (rec_data !== e) begin
                    errors++;
                    $display("FAIL record got %h expected %h", rec_data, e);
                end
            end
        end
    end

    function automatic logic [REC_W-1:0] mk(input logic [TS_W-1:0] ts, input logic of,
                                            input logic [N-1:0] p);
        return {ts, of, p};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ts(input logic [TS_W-1:0] v);
        int k = 0;
        tick(1);
        while (tb_ts != v && k < 200) begin
            tick(1);
            k++;
        end
        if (tb_ts != v) begin
            errors++;
            $display("FAIL wait_ts timeout got %0d expected %0d", tb_ts, v);
        end
    endtask

    task automatic toggle(input int ch, input logic store, input logic of);
        pin[ch] = ~pin[ch];
        te = tb_ts;
        if (store) exp_q.push_back(mk(te + TS_W'(LAT), of, pin));
    endtask

    task automatic check_empty(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s pending %0d expected 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; pin = '0; rise_en = '0; fall_en = '0;
        enable = 1'b0; rec_ready = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(1);
        checks += 4;
        if (rec_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", rec_valid); end
        if (level !== '0) begin errors++; $display("FAIL reset_level got %0d expected 0", level); end
        if (oflow_pend !== 1'b0) begin errors++; $display("FAIL reset_oflow got %b expected 0", oflow_pend); end
        if (rec_data !== '0) begin errors++; $display("FAIL reset_data got %h expected 0", rec_data); end
    endtask

    task automatic test_single_rise;
        rise_en = 7'h01;
        wait_ts(5);
        enable = 1'b1;
        toggle(0, 1'b1, 1'b0);
        tick(LAT + 1);
        checks++;
        if (rec_valid !== 1'b0) begin errors++; $display("FAIL rise_early got %b expected 0", rec_valid); end
        tick(1);
        checks++;
        if (rec_valid !== 1'b1) begin errors++; $display("FAIL rise_latency got %b expected 1", rec_valid); end
        tick(10);
        check_empty("single_rise");
        enable = 1'b0;
    endtask

    task automatic test_glitch_bounce;
        rise_en = 7'h02;
        wait_ts(5);
        enable = 1'b1;
        pin[1] = 1'b1; tick(1); pin[1] = 1'b0;
        tick(12);
        check_empty("glitch");
        pin[1] = 1'b1; te = tb_ts;
        tick(1); pin[1] = 1'b0;
        tick(2); pin[1] = 1'b1;
        exp_q.push_back(mk(te + TS_W'(LAT + 3), 1'b0, pin));
        tick(14);
        check_empty("bounce");
        enable = 1'b0;
    endtask

    task automatic test_edge_mask;
        rise_en = '0; fall_en = 7'h04;
        wait_ts(5);
        enable = 1'b1;
        pin[2] = 1'b1;
        tick(10);
        toggle(2, 1'b1, 1'b0);
        tick(10);
        check_empty("fall_only");
        enable = 1'b0;
    endtask

    task automatic test_enable;
        rise_en = 7'h08; fall_en = '0;
        wait_ts(5);
        toggle(3, 1'b0, 1'b0);
        tick(10);
        enable = 1'b1;
        tick(10);
        check_empty("enable_gate");
        checks++;
        if (level !== '0) begin errors++; $display("FAIL enable_level got %0d expected 0", level); end
        enable = 1'b0;
    endtask

    task automatic test_rollover;
        rise_en = '0; fall_en = '0;
        wait_ts(58);
        enable = 1'b1;
        exp_q.push_back(mk('0, 1'b0, pin));
        wait_ts(8);
        enable = 1'b0;
        tick(4);
        check_empty("rollover");
    endtask

    task automatic test_coincide;
        rise_en = 7'h20;
        wait_ts(50);
        enable = 1'b1;
        wait_ts(64 - LAT);
        pin[5] = 1'b1;
        exp_q.push_back(mk('0, 1'b0, pin));
        wait_ts(8);
        enable = 1'b0;
        tick(4);
        check_empty("coincide");
    endtask

    task automatic test_overflow;
        rise_en = 7'h08; fall_en = 7'h08;
        tick(8);
        rec_ready = 1'b0;
        wait_ts(3);
        enable = 1'b1;
        for (int k = 0; k < 6; k++) begin
            toggle(3, k < 4, 1'b0);
            tick(6);
        end
        tick(2);
        checks += 2;
        if (level !== 3'd4) begin errors++; $display("FAIL ovf_level got %0d expected 4", level); end
        if (oflow_pend !== 1'b1) begin errors++; $display("FAIL ovf_pend got %b expected 1", oflow_pend); end
        rec_ready = 1'b1; tick(1); rec_ready = 1'b0;
        checks++;
        if (level !== 3'd3) begin errors++; $display("FAIL ovf_pop_level got %0d expected 3", level); end
`ifdef LA_DROPCNT_EN
        checks++;
        if (drop_cnt !== 16'd2) begin errors++; $display("FAIL drop_cnt got %0d expected 2", drop_cnt); end
`endif
        toggle(3, 1'b1, 1'b1);
        tick(6);
        checks += 2;
        if (oflow_pend !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b expected 0", oflow_pend); end
        if (level !== 3'd4) begin errors++; $display("FAIL ovf_refill got %0d expected 4", level); end
`ifdef LA_DROPCNT_EN
        checks++;
        if (drop_cnt !== 16'd0) begin errors++; $display("FAIL drop_cnt_clr got %0d expected 0", drop_cnt); end
`endif
        enable = 1'b0;
        rec_ready = 1'b1;
        tick(4);
        checks++;
        if (level !== '0) begin errors++; $display("FAIL back_to_back level got %0d expected 0", level); end
        check_empty("overflow_drain");
    endtask

    task automatic test_async_reset;
        rise_en = '0; fall_en = '0; pin = '0;
        tick(8);
        rise_en = 7'h08; fall_en = 7'h08;
        rec_ready = 1'b0;
        wait_ts(3);
        enable = 1'b1;
        for (int k = 0; k < 5; k++) begin
            toggle(3, k < 4, 1'b0);
            tick(6);
        end
        tick(2);
        checks += 2;
        if (level !== 3'd4) begin errors++; $display("FAIL rst_pre_level got %0d expected 4", level); end
        if (oflow_pend !== 1'b1) begin errors++; $display("FAIL rst_pre_pend got %b expected 1", oflow_pend); end
        rec_ready = 1'b1;
        tick(1);
        checks++;
        if (level !== 3'd3) begin errors++; $display("FAIL rst_mid_level got %0d expected 3", level); end
        #2 rst_n = 1'b0;
        #1;
        checks += 3;
        if (rec_valid !== 1'b0) begin errors++; $display("FAIL async_valid got %b expected 0", rec_valid); end
        if (level !== '0) begin errors++; $display("FAIL async_level got %0d expected 0", level); end
        if (oflow_pend !== 1'b0) begin errors++; $display("FAIL async_pend got %b expected 0", oflow_pend); end
        exp_q.delete();
        enable = 1'b0; pin = '0;
        @(posedge clk); #1 rst_n = 1'b1;
        tick(8);
        wait_ts(5);
        enable = 1'b1;
        toggle(3, 1'b1, 1'b0);
        tick(12);
        check_empty("post_reset");
        enable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_rise();
        test_glitch_bounce();
        test_edge_mask();
        test_enable();
        test_rollover();
        test_coincide();
        test_overflow();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
